// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg                                                              |
// | Shared AHB-Lite encodings and the RAM responder state encoding.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] c_HRESP_OKAY  = 2'b00;
    localparam logic [1:0] c_HRESP_ERROR = 2'b01;

    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_byte_lane_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_byte_lane_dec                                                    |
// | Maps (hsize, haddr[1:0]) to little-endian byte strobes plus an       |
// | illegal-size / misalignment flag.                                    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ahb_byte_lane_dec
    import ahb_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_strb,
    output logic       o_err
);

    always_comb begin
        o_strb = 4'b0000;
        o_err  = 1'b0;
        case (i_hsize)
            c_HSIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
            c_HSIZE_HALF: begin
                o_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_err  = i_addr_lo[0];
            end
            c_HSIZE_WORD: begin
                o_strb = 4'b1111;
                o_err  = |i_addr_lo;
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_slv_ram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_slv_ram_resp                                                     |
// | AHB-Lite RAM slave with configurable wait states and two-cycle       |
// | ERROR response for illegal or out-of-range transfers.                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ahb_slv_ram_resp
    import ahb_pkg::*;
#(
    parameter int P_DEPTH_LOG2 = 6,
    parameter int P_WAIT       = 0,
    parameter int P_WIN_LOG2   = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ahb_haddr,
    input  logic [1:0]  ahb_htrans,
    input  logic        ahb_hwrite,
    input  logic [2:0]  ahb_hsize,
    input  logic [2:0]  ahb_hburst,
    input  logic [3:0]  ahb_hprot,
    input  logic [31:0] ahb_hwdata,
    input  logic        ahb_hlock,
    input  logic        ahb_hsel,
    input  logic        ahb_hready,
    output logic [31:0] ahb_hrdata,
    output logic        ahb_hreadyout,
    output logic [1:0]  ahb_hresp
);

    localparam int         c_DEPTH = 1 << P_DEPTH_LOG2;
    localparam logic [2:0] c_WAIT  = 3'(P_WAIT);

    ahb_state_e r_state;
    ahb_state_e w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    logic                    r_dp_valid;
    logic                    r_dp_write;
    logic [3:0]              r_dp_strb;
    logic [P_DEPTH_LOG2-1:0] r_dp_idx;
    logic [31:0]             r_mem [0:c_DEPTH-1];

    logic [3:0] w_strb;
    logic       w_size_err;
    logic       w_range_err;
    logic       w_xfer_err;
    logic       w_accept;
    logic       w_complete;
    logic       w_we;

    wire w_unused_ok = ^{ahb_hburst, ahb_hprot, ahb_hlock, ahb_htrans[0], ahb_haddr};

    ahb_byte_lane_dec u_lane_dec (
        .i_hsize   (ahb_hsize),
        .i_addr_lo (ahb_haddr[1:0]),
        .o_strb    (w_strb),
        .o_err     (w_size_err)
    );

    generate
        if (P_WIN_LOG2 > P_DEPTH_LOG2 + 2) begin : g_range_chk
            assign w_range_err = |ahb_haddr[P_WIN_LOG2-1:P_DEPTH_LOG2+2];
        end else begin : g_range_none
            assign w_range_err = 1'b0;
        end
    endgenerate

    assign w_xfer_err    = w_size_err | w_range_err;
    assign ahb_hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign ahb_hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? c_HRESP_ERROR
                                                                         : c_HRESP_OKAY;
    assign w_accept      = ahb_hsel & ahb_hready & ahb_htrans[1] & ahb_hreadyout;
    // The data phase of a good transfer always ends in an IDLE cycle.
    assign w_complete    = (r_state == ST_IDLE) & r_dp_valid;
    assign w_we          = w_complete & r_dp_write & resetn;
    assign ahb_hrdata    = (w_complete & ~r_dp_write) ? r_mem[r_dp_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    if (w_xfer_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (P_WAIT != 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dp_valid <= 1'b0;
        end else if (w_accept && !w_xfer_err) begin
            r_dp_valid <= 1'b1;
            r_dp_write <= ahb_hwrite;
            r_dp_strb  <= w_strb;
            r_dp_idx   <= ahb_haddr[P_DEPTH_LOG2+1:2];
        end else if (w_complete) begin
            r_dp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_dp_strb[b]) r_mem[r_dp_idx][8*b +: 8] <= ahb_hwdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_slv_ram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_slv_ram_resp                                                  |
// | Scoreboard bench: one zero-wait and one 3-wait-state instance.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_ahb_slv_ram_resp;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
        logic        sel;
    } xfer_t;

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite, hlock, hsel0, hsel3, use3;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] rdata0, rdata3, a_rdata;
    logic        rdy0, rdy3, a_rdy, hready;
    logic [1:0]  resp0, resp3, a_resp;

    xfer_t       seq[$];
    exp_t        sb[$];
    logic [31:0] mdl [0:63];
    int          n_pass = 0;
    int          n_total = 0;
    int          wait_cnt = 0;
    logic        err1_seen = 1'b0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    assign a_rdy   = use3 ? rdy3 : rdy0;
    assign a_resp  = use3 ? resp3 : resp0;
    assign a_rdata = use3 ? rdata3 : rdata0;
    assign hready  = a_rdy;

    ahb_slv_ram_resp #(.P_DEPTH_LOG2(6), .P_WAIT(0), .P_WIN_LOG2(12)) u_dut0 (
        .clk(clk), .resetn(resetn), .ahb_haddr(haddr), .ahb_htrans(htrans),
        .ahb_hwrite(hwrite), .ahb_hsize(hsize), .ahb_hburst(hburst), .ahb_hprot(hprot),
        .ahb_hwdata(hwdata), .ahb_hlock(hlock), .ahb_hsel(hsel0), .ahb_hready(hready),
        .ahb_hrdata(rdata0), .ahb_hreadyout(rdy0), .ahb_hresp(resp0)
    );

    ahb_slv_ram_resp #(.P_DEPTH_LOG2(6), .P_WAIT(3), .P_WIN_LOG2(12)) u_dut3 (
        .clk(clk), .resetn(resetn), .ahb_haddr(haddr), .ahb_htrans(htrans),
        .ahb_hwrite(hwrite), .ahb_hsize(hsize), .ahb_hburst(hburst), .ahb_hprot(hprot),
        .ahb_hwdata(hwdata), .ahb_hlock(hlock), .ahb_hsel(hsel3), .ahb_hready(hready),
        .ahb_hrdata(rdata3), .ahb_hreadyout(rdy3), .ahb_hresp(resp3)
    );

    function automatic logic m_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) ||
               (a[11:0] >= 12'd256);
    endfunction

    function automatic logic [3:0] m_lanes(input logic [31:0] a, input logic [2:0] s);
        case (s)
            3'd0:    return 4'b0001 << a[1:0];
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [1:0] trans, input logic sel);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata; x.trans = trans; x.sel = sel;
        seq.push_back(x);
    endtask

    // Drives the queued transfers pipelined; expectations enter the
    // scoreboard at the accepting edge, in bus order.
    task automatic run_seq(input string tag);
        int guard;
        logic rdy, ok;
        exp_t e;
        logic [3:0] ln;
        int idx;
        foreach (seq[i]) begin
            haddr  = seq[i].addr;
            htrans = seq[i].trans;
            hwrite = seq[i].wr;
            hsize  = seq[i].size;
            hburst = 3'($urandom);
            hprot  = 4'($urandom);
            hlock  = 1'($urandom);
            if (use3) hsel3 = seq[i].sel; else hsel0 = seq[i].sel;
            guard = 0; ok = 1'b0;
            while (!ok && guard < 20) begin
                @(negedge clk); rdy = hready;
                @(posedge clk); ok = rdy; guard++;
            end
            if (!ok) begin
                n_total++;
                $display("FAIL %s_accept: hready stayed 0, required 1 within 20 cycles", tag);
            end else if (seq[i].sel && seq[i].trans[1]) begin
                e.wr = seq[i].wr;
                e.err = m_err(seq[i].addr, seq[i].size);
                e.waits = e.err ? 0 : (use3 ? 3 : 0);
                e.rdata = 32'h0;
                idx = int'(seq[i].addr[7:2]);
                ln = m_lanes(seq[i].addr, seq[i].size);
                if (!e.err && e.wr) begin
                    for (int b = 0; b < 4; b++)
                        if (ln[b]) mdl[idx][8*b +: 8] = seq[i].wdata[8*b +: 8];
                end else if (!e.err) begin
                    e.rdata = mdl[idx];
                end
                sb.push_back(e);
            end
            #1;
            hwdata = seq[i].wdata;
        end
        htrans = 2'b00; hsel0 = 1'b0; hsel3 = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin @(posedge clk); guard++; end
        n_total++;
        if (sb.size() != 0) $display("FAIL %s_drain: %0d pending, required 0", tag, sb.size());
        else n_pass++;
        #1;
        seq.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                n_total++;
                if ({a_rdy, a_resp, a_rdata} !== {1'b1, 2'b00, 32'h0})
                    $display("FAIL idle_out: rdy=%b resp=%b rdata=%h required 1/00/00000000",
                             a_rdy, a_resp, a_rdata);
                else n_pass++;
            end else if (!a_rdy) begin
                n_total++;
                if (a_resp === 2'b01) begin
                    if (!sb[0].err || err1_seen)
                        $display("FAIL err1_cycle: resp=01 rdy=0, required err=%b first=1", sb[0].err);
                    else n_pass++;
                    err1_seen = 1'b1;
                end else begin
                    wait_cnt++;
                    if (sb[0].err || a_resp !== 2'b00 || a_rdata !== 32'h0)
                        $display("FAIL wait_cycle: resp=%b rdata=%h err=%b, required 00/00000000/0",
                                 a_resp, a_rdata, sb[0].err);
                    else n_pass++;
                end
            end else begin
                n_total++;
                if (a_resp !== (sb[0].err ? 2'b01 : 2'b00))
                    $display("FAIL final_resp: resp=%b, required %b", a_resp, sb[0].err ? 2'b01 : 2'b00);
                else n_pass++;
                n_total++;
                if (sb[0].err ? !err1_seen : (wait_cnt != sb[0].waits))
                    $display("FAIL phase_len: waits=%0d err1=%b, required waits=%0d err=%b",
                             wait_cnt, err1_seen, sb[0].waits, sb[0].err);
                else n_pass++;
                n_total++;
                if (a_rdata !== ((!sb[0].err && !sb[0].wr) ? sb[0].rdata : 32'h0))
                    $display("FAIL rdata: got %h, required %h", a_rdata,
                             (!sb[0].err && !sb[0].wr) ? sb[0].rdata : 32'h0);
                else n_pass++;
                void'(sb.pop_front());
                wait_cnt = 0;
                err1_seen = 1'b0;
            end
        end
    end

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({rdy0, resp0, rdata0} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL reset_dut0: rdy=%b resp=%b rdata=%h required 1/00/0", rdy0, resp0, rdata0);
        else n_pass++;
        n_total++;
        if ({rdy3, resp3, rdata3} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL reset_dut3: rdy=%b resp=%b rdata=%h required 1/00/0", rdy3, resp3, rdata3);
        else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        use3 = 1'b0;
        add(1'b1, 32'h010, 3'd2, 32'h12345678, 2'b10, 1'b1);
        add(1'b0, 32'h010, 3'd2, 32'hFFFFFFFF, 2'b10, 1'b1);
        add(1'b1, 32'h0FC, 3'd2, 32'hA5A5C3C3, 2'b10, 1'b1);
        add(1'b0, 32'h0FC, 3'd2, 32'h0, 2'b11, 1'b1);
        add(1'b0, 32'h010, 3'd2, 32'h0, 2'b11, 1'b1);
        run_seq("b2b");
    endtask

    task automatic test_byte_lanes();
        use3 = 1'b0;
        add(1'b1, 32'h020, 3'd2, 32'h00000000, 2'b10, 1'b1);
        add(1'b1, 32'h021, 3'd0, 32'hFFFFABFF, 2'b10, 1'b1);
        add(1'b0, 32'h020, 3'd2, 32'h0, 2'b10, 1'b1);
        add(1'b1, 32'h024, 3'd2, 32'h11223344, 2'b10, 1'b1);
        add(1'b1, 32'h026, 3'd1, 32'hBEEF7777, 2'b10, 1'b1);
        add(1'b1, 32'h024, 3'd0, 32'h999999EE, 2'b10, 1'b1);
        add(1'b0, 32'h024, 3'd2, 32'h0, 2'b10, 1'b1);
        run_seq("lanes");
    endtask

    task automatic test_wait();
        use3 = 1'b1;
        add(1'b1, 32'h000, 3'd2, 32'hCAFEF00D, 2'b10, 1'b1);
        add(1'b0, 32'h000, 3'd2, 32'h0, 2'b10, 1'b1);
        add(1'b1, 32'h003, 3'd0, 32'h77000000, 2'b10, 1'b1);
        add(1'b0, 32'h000, 3'd2, 32'h0, 2'b10, 1'b1);
        run_seq("wait");
    endtask

    task automatic test_errors();
        use3 = 1'b0;
        add(1'b1, 32'h0A0, 3'd2, 32'h55AA55AA, 2'b10, 1'b1);
        add(1'b1, 32'h0A2, 3'd2, 32'hDEADDEAD, 2'b10, 1'b1);
        add(1'b0, 32'h0A0, 3'd2, 32'h0, 2'b10, 1'b1);
        add(1'b0, 32'h100, 3'd2, 32'h0, 2'b10, 1'b1);
        add(1'b1, 32'h0A0, 3'd3, 32'h01010101, 2'b10, 1'b1);
        add(1'b1, 32'h0A1, 3'd1, 32'h02020202, 2'b10, 1'b1);
        add(1'b1, 32'h102, 3'd2, 32'h03030303, 2'b10, 1'b1);
        add(1'b0, 32'h0A0, 3'd2, 32'h0, 2'b10, 1'b1);
        run_seq("err0");
        use3 = 1'b1;
        add(1'b0, 32'h100, 3'd2, 32'h0, 2'b10, 1'b1);
        add(1'b0, 32'h000, 3'd2, 32'h0, 2'b10, 1'b1);
        run_seq("err3");
    endtask

    task automatic test_idle_busy();
        use3 = 1'b0;
        mon_en = 1'b0;
        haddr = 32'h010; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b01; hsel0 = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'hFFFFFFFF; htrans = 2'b00; hsel0 = 1'b0;
        @(negedge clk);
        n_total++;
        if ({rdy0, resp0, rdata0} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL busy_resp: rdy=%b resp=%b rdata=%h required 1/00/0", rdy0, resp0, rdata0);
        else n_pass++;
        @(posedge clk); #1;
        mon_en = 1'b1;
        add(1'b1, 32'h010, 3'd2, 32'hEEEEEEEE, 2'b01, 1'b1);
        add(1'b1, 32'h010, 3'd2, 32'hDDDDDDDD, 2'b10, 1'b0);
        add(1'b1, 32'h010, 3'd2, 32'hCCCCCCCC, 2'b00, 1'b1);
        add(1'b0, 32'h010, 3'd2, 32'h0, 2'b10, 1'b1);
        run_seq("idle");
    endtask

    task automatic test_reset_mid_wait();
        use3 = 1'b1;
        add(1'b1, 32'h040, 3'd2, 32'h11111111, 2'b10, 1'b1);
        run_seq("rst_pre");
        mon_en = 1'b0;
        haddr = 32'h040; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hsel3 = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'hDEADBEEF; htrans = 2'b00; hsel3 = 1'b0;
        @(negedge clk);
        n_total++;
        if (rdy3 !== 1'b0) $display("FAIL rst_wait_entry: rdy=%b required 0", rdy3);
        else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        n_total++;
        if ({rdy3, resp3, rdata3} !== {1'b1, 2'b00, 32'h0})
            $display("FAIL rst_mid_wait: rdy=%b resp=%b rdata=%h required 1/00/0", rdy3, resp3, rdata3);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        add(1'b0, 32'h040, 3'd2, 32'h0, 2'b10, 1'b1);
        run_seq("rst_post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        haddr = 32'h0; hwdata = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        hburst = 3'd0; hprot = 4'd0; hlock = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; use3 = 1'b0;
        resetn = 1'b0;
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait();
        test_errors();
        test_idle_busy();
        test_reset_mid_wait();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
